pcoeff_sum_accumulator: RTL and testbench

//  Consumes the result stream of the streaming count-connected core: one result per clk, no stall.

---
 rtl/pcoeff_sum_accumulator.sv | 79 +++++++
 tb/tb_pcoeff_sum_accumulator.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/pcoeff_sum_accumulator.sv
// pcoeff_sum_accumulator: sums 2^connectCount per batch and queues {sum, count, flags} records.
module pcoeff_sum_accumulator #(
   parameter int SUM_WIDTH   = 48,
   parameter int COUNT_WIDTH = 32,
   parameter int OUT_DEPTH   = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   resultValid,
   input  logic [5:0]             connectCount,
   input  logic                   batchEnd,
   input  logic                   eccIn,
   output logic                   outValid,
   input  logic                   outReady,
   output logic [SUM_WIDTH-1:0]   outSum,
   output logic [COUNT_WIDTH-1:0] outBotCount,
   output logic [2:0]             outFlags,
   output logic                   droppedBatch
);
   localparam int AW = $clog2(OUT_DEPTH);
   localparam int RW = SUM_WIDTH + COUNT_WIDTH + 3;
   logic                   s1_valid, s1_end, s1_ecc, s1_wide, in_wide;
   logic [SUM_WIDTH-1:0]   s1_term, acc, sum_nx;
   logic                   carry;
   logic [COUNT_WIDTH-1:0] cnt, cnt_nx;
   logic [2:0]             flags, flags_nx;
   logic                   rec_valid;
   logic [RW-1:0]          rec;
   logic [RW-1:0]          mem [OUT_DEPTH];
   logic [AW-1:0]          wp, rp;
   logic [AW:0]            occ;
   logic                   full, pop, push;
   assign in_wide  = resultValid && (32'(connectCount) >= SUM_WIDTH);
   assign {carry, sum_nx} = {1'b0, acc} + {1'b0, s1_term};
   assign cnt_nx   = cnt + COUNT_WIDTH'(s1_valid);
   assign flags_nx = flags | {s1_ecc, s1_wide, carry};
   assign full     = occ == (AW+1)'(OUT_DEPTH);
   assign outValid = occ != '0;
   assign pop      = outValid && outReady;
   // a pop in the same cycle frees the slot for the incoming record
   assign push     = rec_valid && (!full || pop);
   assign {outSum, outBotCount, outFlags} = outValid ? mem[rp] : '0;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid     <= 1'b0;
         s1_end       <= 1'b0;
         s1_ecc       <= 1'b0;
         s1_wide      <= 1'b0;
         s1_term      <= '0;
         acc          <= '0;
         cnt          <= '0;
         flags        <= '0;
         rec_valid    <= 1'b0;
         rec          <= '0;
         wp           <= '0;
         rp           <= '0;
         occ          <= '0;
         droppedBatch <= 1'b0;
      end else begin
         s1_valid     <= resultValid;
         s1_end       <= batchEnd;
         s1_ecc       <= eccIn;
         s1_wide      <= in_wide;
         s1_term      <= (resultValid && !in_wide) ? SUM_WIDTH'(1) << connectCount : '0;
         acc          <= s1_end ? '0 : sum_nx;
         cnt          <= s1_end ? '0 : cnt_nx;
         flags        <= s1_end ? '0 : flags_nx;
         rec_valid    <= s1_end;
         rec          <= {sum_nx, cnt_nx, flags_nx};
         wp           <= push ? wp + AW'(1) : wp;
         rp           <= pop ? rp + AW'(1) : rp;
         occ          <= occ + (AW+1)'(push) - (AW+1)'(pop);
         droppedBatch <= droppedBatch | (rec_valid && !push);
      end
   end
   always_ff @(posedge clk) begin
      if (push) mem[wp] <= rec;
   end
endmodule

// File: tb/tb_pcoeff_sum_accumulator.sv
// tb_pcoeff_sum_accumulator: directed vectors with hand-computed records.
module tb_pcoeff_sum_accumulator;
   logic        clk = 1'b0;
   logic        rst_n, resultValid, batchEnd, eccIn, outReady;
   logic [5:0]  connectCount;
   logic        outValid, droppedBatch;
   logic [47:0] outSum;
   logic [31:0] outBotCount;
   logic [2:0]  outFlags;
   int          n_run = 0;
   int          n_fail = 0;
   always #5 clk = ~clk;
   pcoeff_sum_accumulator dut (
      .clk(clk), .rst_n(rst_n), .resultValid(resultValid), .connectCount(connectCount),
      .batchEnd(batchEnd), .eccIn(eccIn), .outValid(outValid), .outReady(outReady),
      .outSum(outSum), .outBotCount(outBotCount), .outFlags(outFlags), .droppedBatch(droppedBatch)
   );
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic step(input logic v, input logic [5:0] c, input logic e, input logic ecc);
      resultValid = v;
      connectCount = c;
      batchEnd = e;
      eccIn = ecc;
      @(posedge clk);
      #1;
   endtask
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 6'd0, 1'b0, 1'b0);
   endtask
   task automatic rec(input string tag, input logic [47:0] s, input logic [31:0] c, input logic [2:0] f);
      chk({tag, ".valid"}, 64'(outValid), 64'd1);
      chk({tag, ".sum"}, 64'(outSum), 64'(s));
      chk({tag, ".count"}, 64'(outBotCount), 64'(c));
      chk({tag, ".flags"}, 64'(outFlags), 64'(f));
   endtask
   task automatic pop();
      outReady = 1'b1;
      idle(1);
      outReady = 1'b0;
   endtask
   task automatic do_reset();
      rst_n = 1'b0;
      idle(2);
      rst_n = 1'b1;
   endtask
   initial begin
      outReady = 1'b0;
      step(1'b0, 6'd0, 1'b0, 1'b0);
      do_reset();
      chk("rst.valid", 64'(outValid), 64'd0);
      chk("rst.sum", 64'(outSum), 64'd0);
      chk("rst.count", 64'(outBotCount), 64'd0);
      chk("rst.flags", 64'(outFlags), 64'd0);
      chk("rst.drop", 64'(droppedBatch), 64'd0);
      // basic sum 1+2+32 with exact latency
      step(1'b1, 6'd0, 1'b0, 1'b0);
      step(1'b1, 6'd1, 1'b0, 1'b0);
      step(1'b1, 6'd5, 1'b1, 1'b0);
      idle(1);
      chk("lat.early", 64'(outValid), 64'd0);
      idle(1);
      rec("t1", 48'd35, 32'd3, 3'b000);
      pop();
      chk("t1.popped", 64'(outValid), 64'd0);
      // invalid cycles with wide count are ignored
      step(1'b1, 6'd2, 1'b0, 1'b0);
      step(1'b0, 6'd63, 1'b0, 1'b0);
      step(1'b0, 6'd63, 1'b0, 1'b0);
      step(1'b1, 6'd3, 1'b1, 1'b0);
      idle(2);
      rec("t2", 48'd12, 32'd2, 3'b000);
      pop();
      // empty batch
      step(1'b0, 6'd63, 1'b1, 1'b0);
      idle(2);
      rec("empty", 48'd0, 32'd0, 3'b000);
      pop();
      // too-wide term, then wrap
      step(1'b1, 6'd48, 1'b1, 1'b0);
      step(1'b1, 6'd47, 1'b0, 1'b0);
      step(1'b1, 6'd47, 1'b1, 1'b0);
      idle(1);
      rec("wide", 48'd0, 32'd1, 3'b010);
      pop();
      rec("wrap", 48'd0, 32'd2, 3'b001);
      pop();
      // ecc only marks its own batch
      step(1'b1, 6'd0, 1'b0, 1'b1);
      step(1'b1, 6'd0, 1'b1, 1'b0);
      step(1'b1, 6'd1, 1'b1, 1'b0);
      idle(1);
      rec("ecc", 48'd2, 32'd2, 3'b100);
      pop();
      rec("noecc", 48'd2, 32'd1, 3'b000);
      pop();
      chk("ecc.empty", 64'(outValid), 64'd0);
      // full buffer with simultaneous push and pop
      for (int i = 0; i < 4; i++) step(1'b1, 6'(i), 1'b1, 1'b0);
      idle(2);
      step(1'b1, 6'd10, 1'b1, 1'b0);
      idle(1);
      outReady = 1'b1;
      idle(1);
      outReady = 1'b0;
      chk("pp.drop", 64'(droppedBatch), 64'd0);
      rec("pp0", 48'd2, 32'd1, 3'b000);
      pop();
      rec("pp1", 48'd4, 32'd1, 3'b000);
      pop();
      rec("pp2", 48'd8, 32'd1, 3'b000);
      pop();
      rec("pp3", 48'd1024, 32'd1, 3'b000);
      pop();
      chk("pp.empty", 64'(outValid), 64'd0);
      // overflow drops the fifth record
      for (int i = 0; i < 5; i++) step(1'b1, 6'(i), 1'b1, 1'b0);
      idle(3);
      chk("ov.drop", 64'(droppedBatch), 64'd1);
      for (int i = 0; i < 4; i++) begin
         rec($sformatf("ov%0d", i), 48'd1 << i, 32'd1, 3'b000);
         pop();
      end
      chk("ov.empty", 64'(outValid), 64'd0);
      // reset mid-batch
      step(1'b1, 6'd0, 1'b0, 1'b0);
      step(1'b1, 6'd1, 1'b0, 1'b0);
      step(1'b1, 6'd2, 1'b0, 1'b0);
      idle(1);
      do_reset();
      chk("mid.valid", 64'(outValid), 64'd0);
      chk("mid.sum", 64'(outSum), 64'd0);
      chk("mid.drop", 64'(droppedBatch), 64'd0);
      step(1'b1, 6'd2, 1'b1, 1'b0);
      idle(2);
      rec("post", 48'd4, 32'd1, 3'b000);
      pop();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
